// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register word indices and the
// width of the post-reset edge-detect warm-up counter.
package gpio_pkg;

    typedef enum logic [2:0] {
        REG_OUT = 3'd0,
        REG_SET = 3'd1,
        REG_CLR = 3'd2,
        REG_TGL = 3'd3,
        REG_DIR = 3'd4,
        REG_IN  = 3'd5,
        REG_IEN = 3'd6,
        REG_IST = 3'd7
    } reg_idx_e;

    // Wide enough to hold SYNC_STAGES+1 for the deepest synchronizer (4).
    localparam int WARM_W = 3;

endpackage

// File: rtl/gpio_ctrl_if.sv
// Register bus between a host and the GPIO controller: write/read strobes,
// word index and data, with a registered read-data/valid return path.
interface gpio_ctrl_if;

    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output we, re, addr, wdata, input rdata, rvalid);
    modport slave  (input we, re, addr, wdata, output rdata, rvalid);

endinterface

// File: rtl/gpio_sync.sv
// Multi-stage input synchronizer for asynchronous pins, with a per-bit
// any-edge detector built from a one-cycle-delayed copy of the last stage.
module gpio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] edges
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  delayed;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain   <= '0;
            delayed <= '0;
        end else begin
            chain   <= {chain[SYNC_STAGES-2:0], pins};
            delayed <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];
    assign edges    = chain[SYNC_STAGES-1] ^ delayed;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: output/direction registers with set/clear/toggle aliases,
// synchronized pin inputs, sticky edge status and a level interrupt.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    gpio_ctrl_if.slave       bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]  out_reg;
    logic [WIDTH-1:0]  dir_reg;
    logic [WIDTH-1:0]  ien_reg;
    logic [WIDTH-1:0]  ist_reg;
    logic [WIDTH-1:0]  sync_in;
    logic [WIDTH-1:0]  edges;
    logic [WIDTH-1:0]  wdata_w;
    logic [WIDTH-1:0]  clr_mask;
    logic [WIDTH-1:0]  edge_set;
    logic [WARM_W-1:0] warm_cnt;
    logic [31:0]       rd_mux;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .pins     (gpio_in),
        .sync_out (sync_in),
        .edges    (edges)
    );

    assign wdata_w  = bus.wdata[WIDTH-1:0];
    assign clr_mask = (bus.we && bus.addr == REG_IST) ? wdata_w : '0;
    // Edges are ignored until the synchronizer has flushed its reset zeros.
    assign edge_set = (warm_cnt == '0) ? edges : '0;

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            REG_OUT: rd_mux[WIDTH-1:0] = out_reg;
            REG_DIR: rd_mux[WIDTH-1:0] = dir_reg;
            REG_IN:  rd_mux[WIDTH-1:0] = sync_in;
            REG_IEN: rd_mux[WIDTH-1:0] = ien_reg;
            REG_IST: rd_mux[WIDTH-1:0] = ist_reg;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg    <= '0;
            dir_reg    <= '0;
            ien_reg    <= '0;
            ist_reg    <= '0;
            warm_cnt   <= WARM_LOAD;
            irq        <= 1'b0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            if (warm_cnt != '0) begin
                warm_cnt <= warm_cnt - 1'b1;
            end
            if (bus.we) begin
                case (bus.addr)
                    REG_OUT: out_reg <= wdata_w;
                    REG_SET: out_reg <= out_reg | wdata_w;
                    REG_CLR: out_reg <= out_reg & ~wdata_w;
                    REG_TGL: out_reg <= out_reg ^ wdata_w;
                    REG_DIR: dir_reg <= wdata_w;
                    REG_IEN: ien_reg <= wdata_w;
                    default: ;
                endcase
            end
            // A new edge outranks a write-one-to-clear on the same bit.
            ist_reg    <= (ist_reg & ~clr_mask) | edge_set;
            irq        <= |(ist_reg & ien_reg);
            bus.rvalid <= bus.re;
            bus.rdata  <= bus.re ? rd_mux : '0;
        end
    end

    assign gpio_out = out_reg;
    assign gpio_oe  = dir_reg;

endmodule
